// File: rtl/ahb_timer_pkg.sv
// Shared definitions for the AHB-Lite system timer.
// Contents: register word offsets, CTRL bit positions, and the two
// run-state encodings (IDLE/RUN) that the EN bit represents.
package ahb_timer_pkg;

    // Register word offsets (HADDR[4:2])
    localparam logic [2:0] TMR_CTRL   = 3'd0;
    localparam logic [2:0] TMR_LOAD   = 3'd1;
    localparam logic [2:0] TMR_COUNT  = 3'd2;
    localparam logic [2:0] TMR_STATUS = 3'd3;
    localparam logic [2:0] TMR_UPTIME = 3'd4;

    // CTRL bit positions
    localparam int CTRL_EN     = 0;
    localparam int CTRL_AUTO   = 1;
    localparam int CTRL_IRQEN  = 2;
    localparam int CTRL_PS_LSB = 8;

    // Run state: the timer is either idle (EN=0) or running (EN=1)
    localparam logic ST_IDLE = 1'b0;
    localparam logic ST_RUN  = 1'b1;

endpackage

// File: rtl/ahb_sys_timer_prescaler.sv
// Prescaler for the system timer.
// Counts pcnt from 0 up to ps while enabled and raises tick on the cycle
// where pcnt == ps; pcnt then restarts from 0.
// Ports:
//   clk_i    bus clock
//   rst_ni   asynchronous active-low reset
//   en_i     timer running; pcnt is held at 0 while low
//   clear_i  force pcnt back to 0 at the next edge
//   ps_i     prescale divisor minus one (0 = tick every cycle)
//   tick_o   one-cycle count strobe
module timer_prescaler #(
    parameter int PS_WIDTH = 8
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                en_i,
    input  logic                clear_i,
    input  logic [PS_WIDTH-1:0] ps_i,
    output logic                tick_o
);

    logic [PS_WIDTH-1:0] pcnt_q, pcnt_d;

    assign tick_o = en_i && (pcnt_q == ps_i);

    always_comb begin
        pcnt_d = pcnt_q + 1'b1;
        if (!en_i || clear_i || tick_o) begin
            pcnt_d = '0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pcnt_q <= '0;
        end else begin
            pcnt_q <= pcnt_d;
        end
    end

endmodule

// File: rtl/ahb_sys_timer.sv
// AHB-Lite system timer peripheral.
// 32-bit down-counter with prescaler, reload value, one-shot/periodic mode,
// sticky MATCH flag with interrupt, and a free-running 32-bit uptime counter.
// Bus handshake: the slave has no wait states. A write takes effect at the
// rising edge of any cycle where HSEL & HWRITE are high (address, write and
// select are already data-phase aligned); a read is the combinational
// HRDATA for the current HADDR, qualified externally by the bus mux.
// Ports:
//   HCLK, HRESETn   clock, asynchronous active-low reset
//   HSEL            slave select (data phase)
//   HADDR[2:0]      word offset (data phase)
//   HWRITE          write strobe (data phase)
//   HWDATA[31:0]    write data
//   HRDATA[31:0]    read data for HADDR
//   irq             STATUS.MATCH & CTRL.IRQ_EN
module ahb_sys_timer
    import ahb_timer_pkg::*;
#(
    parameter int PS_WIDTH = 8
) (
    input  logic        HCLK,
    input  logic        HRESETn,
    input  logic        HSEL,
    input  logic [2:0]  HADDR,
    input  logic        HWRITE,
    input  logic [31:0] HWDATA,
    output logic [31:0] HRDATA,
    output logic        irq
);

    logic                en_q, en_d;
    logic                auto_q, auto_d;
    logic                irq_en_q, irq_en_d;
    logic [PS_WIDTH-1:0] ps_q, ps_d;
    logic [31:0]         load_q, load_d;
    logic [31:0]         count_q, count_d;
    logic                match_q, match_d;
    logic [31:0]         uptime_q, uptime_d;

    logic bus_wr, ctrl_wr, load_wr, count_wr, status_wr;
    logic tick, expire, pcnt_clear;
    logic run_state;

    assign bus_wr    = HSEL && HWRITE;
    assign ctrl_wr   = bus_wr && (HADDR == TMR_CTRL);
    assign load_wr   = bus_wr && (HADDR == TMR_LOAD);
    assign count_wr  = bus_wr && (HADDR == TMR_COUNT);
    assign status_wr = bus_wr && (HADDR == TMR_STATUS);

    assign run_state = en_q ? ST_RUN : ST_IDLE;

    // A fresh enable starts a full prescale period; a COUNT write also
    // restarts the period so the written value gets a whole tick interval.
    assign pcnt_clear = (ctrl_wr && HWDATA[CTRL_EN] && (run_state == ST_IDLE))
                      || count_wr;

    timer_prescaler #(
        .PS_WIDTH (PS_WIDTH)
    ) u_prescaler (
        .clk_i   (HCLK),
        .rst_ni  (HRESETn),
        .en_i    (run_state == ST_RUN),
        .clear_i (pcnt_clear),
        .ps_i    (ps_q),
        .tick_o  (tick)
    );

    assign expire = tick && (count_q == 32'd0);

    always_comb begin
        en_d     = en_q;
        auto_d   = auto_q;
        irq_en_d = irq_en_q;
        ps_d     = ps_q;
        load_d   = load_q;
        count_d  = count_q;
        match_d  = match_q;
        uptime_d = uptime_q + 32'd1;

        // Counting first; bus writes below override it where they collide.
        if (tick) begin
            if (count_q != 32'd0) begin
                count_d = count_q - 32'd1;
            end else begin
                match_d = 1'b1;
                if (auto_q) begin
                    count_d = load_q;
                end else begin
                    en_d = 1'b0;
                end
            end
        end

        if (ctrl_wr) begin
            en_d     = HWDATA[CTRL_EN];
            auto_d   = HWDATA[CTRL_AUTO];
            irq_en_d = HWDATA[CTRL_IRQEN];
            ps_d     = HWDATA[CTRL_PS_LSB +: PS_WIDTH];
        end
        if (load_wr) begin
            load_d = HWDATA;
        end
        if (count_wr) begin
            count_d = HWDATA;
        end
        // An expiry in the same cycle keeps MATCH set.
        if (status_wr && HWDATA[0] && !expire) begin
            match_d = 1'b0;
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            en_q     <= 1'b0;
            auto_q   <= 1'b0;
            irq_en_q <= 1'b0;
            ps_q     <= '0;
            load_q   <= '0;
            count_q  <= '0;
            match_q  <= 1'b0;
            uptime_q <= '0;
        end else begin
            en_q     <= en_d;
            auto_q   <= auto_d;
            irq_en_q <= irq_en_d;
            ps_q     <= ps_d;
            load_q   <= load_d;
            count_q  <= count_d;
            match_q  <= match_d;
            uptime_q <= uptime_d;
        end
    end

    always_comb begin
        HRDATA = '0;
        case (HADDR)
            TMR_CTRL: begin
                HRDATA[CTRL_EN]                     = en_q;
                HRDATA[CTRL_AUTO]                   = auto_q;
                HRDATA[CTRL_IRQEN]                  = irq_en_q;
                HRDATA[CTRL_PS_LSB +: PS_WIDTH]     = ps_q;
            end
            TMR_LOAD:   HRDATA = load_q;
            TMR_COUNT:  HRDATA = count_q;
            TMR_STATUS: HRDATA[0] = match_q;
            TMR_UPTIME: HRDATA = uptime_q;
            default:    HRDATA = '0;
        endcase
    end

    assign irq = match_q && irq_en_q;

endmodule

// File: tb/tb_ahb_sys_timer.sv
// Testbench for ahb_sys_timer: register table, directed multi-cycle
// sequences, and randomized enable/run segments against an arithmetic model.
module tb_ahb_sys_timer;
    import ahb_timer_pkg::*;

    logic        HCLK;
    logic        HRESETn;
    logic        HSEL;
    logic [2:0]  HADDR;
    logic        HWRITE;
    logic [31:0] HWDATA;
    logic [31:0] HRDATA;
    logic        irq;

    int n_checks = 0;
    int n_pass   = 0;
    logic [31:0] exp_q[$];
    int unsigned up_cyc;

    ahb_sys_timer #(
        .PS_WIDTH (8)
    ) dut (
        .HCLK    (HCLK),
        .HRESETn (HRESETn),
        .HSEL    (HSEL),
        .HADDR   (HADDR),
        .HWRITE  (HWRITE),
        .HWDATA  (HWDATA),
        .HRDATA  (HRDATA),
        .irq     (irq)
    );

    // ---------------- clock / reset ----------------
    initial HCLK = 1'b0;
    always #20 HCLK = ~HCLK;

    // Reference cycle count since reset release (expected UPTIME).
    always @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) up_cyc <= 0;
        else          up_cyc <= up_cyc + 1;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: time limit reached, got no end, required $finish");
        $fatal(1, "watchdog");
    end

    // ---------------- driver tasks ----------------
    // All tasks start and end shortly after a falling edge.
    task automatic step(input int n);
        repeat (n) @(negedge HCLK);
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        HSEL = 1'b1; HWRITE = 1'b1; HADDR = a; HWDATA = d;
        @(negedge HCLK);
        HSEL = 1'b0; HWRITE = 1'b0;
    endtask

    task automatic rd(input logic [2:0] a, output logic [31:0] d);
        HSEL = 1'b0; HWRITE = 1'b0; HADDR = a;
        #1;
        d = HRDATA;
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, required 0x%08h", name, got, exp);
    endtask

    task automatic chk_rd(input string name, input logic [2:0] a, input logic [31:0] exp);
        logic [31:0] d;
        rd(a, d);
        chk(name, d, exp);
    endtask

    task automatic chk_irq(input string name, input logic exp);
        #1;
        chk(name, {31'd0, irq}, {31'd0, exp});
    endtask

    // ---------------- table vectors ----------------
    typedef struct {
        logic [2:0]  waddr;
        logic [31:0] wdata;
        logic [2:0]  raddr;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[11];

    // ---------------- main ----------------
    initial begin
        logic [31:0] d, a0, a1;
        int n;

        HRESETn = 1'b0; HSEL = 1'b0; HWRITE = 1'b0; HADDR = '0; HWDATA = '0;
        step(3);
        HRESETn = 1'b1;

        // Reset values
        for (int i = 0; i < 8; i++) begin
            if (i != 4) chk_rd("reset_val", 3'(i), 32'd0);
        end
        chk_irq("reset_irq", 1'b0);

        // Register table: write then read back (EN kept 0 so nothing counts)
        vecs[0]  = '{TMR_CTRL,   32'hFFFF_FFF0, TMR_CTRL,   32'h0000_FF00};
        vecs[1]  = '{TMR_CTRL,   32'h0000_0006, TMR_CTRL,   32'h0000_0006};
        vecs[2]  = '{TMR_LOAD,   32'hA5A5_5A5A, TMR_LOAD,   32'hA5A5_5A5A};
        vecs[3]  = '{TMR_COUNT,  32'h1234_5678, TMR_COUNT,  32'h1234_5678};
        vecs[4]  = '{TMR_STATUS, 32'hFFFF_FFFF, TMR_STATUS, 32'h0000_0000};
        vecs[5]  = '{3'd5,       32'hDEAD_BEEF, 3'd5,       32'h0000_0000};
        vecs[6]  = '{3'd6,       32'hFFFF_FFFF, 3'd6,       32'h0000_0000};
        vecs[7]  = '{3'd7,       32'h0000_0001, TMR_COUNT,  32'h1234_5678};
        vecs[8]  = '{TMR_COUNT,  32'h0000_0000, TMR_COUNT,  32'h0000_0000};
        vecs[9]  = '{TMR_CTRL,   32'h0000_0000, TMR_CTRL,   32'h0000_0000};
        vecs[10] = '{TMR_LOAD,   32'h0000_0000, TMR_LOAD,   32'h0000_0000};
        for (int i = 0; i < 11; i++) begin
            wr(vecs[i].waddr, vecs[i].wdata);
            chk_rd($sformatf("table_%0d", i), vecs[i].raddr, vecs[i].exp);
        end

        // Asynchronous reset mid-run
        wr(TMR_COUNT, 32'h10);
        wr(TMR_CTRL, 32'h7);
        step(3);
        #3 HRESETn = 1'b0;
        #1;
        for (int i = 0; i < 8; i++) chk_rd("in_reset_val", 3'(i), 32'd0);
        chk_irq("in_reset_irq", 1'b0);
        @(negedge HCLK);
        HRESETn = 1'b1;
        for (int i = 0; i < 8; i++) begin
            if (i != 4) chk_rd("post_reset_val", 3'(i), 32'd0);
        end
        for (int i = 0; i < 20; i++) begin
            step(1);
            chk_rd("post_reset_count", TMR_COUNT, 32'd0);
        end
        chk_rd("post_reset_uptime", TMR_UPTIME, 32'd20);

        // Periodic, PS=0
        wr(TMR_LOAD, 32'd3);
        wr(TMR_COUNT, 32'd3);
        wr(TMR_CTRL, 32'h7);
        chk_rd("per_count0", TMR_COUNT, 32'd3);
        for (int i = 1; i <= 3; i++) begin
            step(1);
            chk_rd("per_count", TMR_COUNT, 32'(3 - i));
            chk_rd("per_nomatch", TMR_STATUS, 32'd0);
        end
        step(1);
        chk_rd("per_reload", TMR_COUNT, 32'd3);
        chk_rd("per_match", TMR_STATUS, 32'd1);
        chk_irq("per_irq", 1'b1);
        for (int i = 1; i <= 4; i++) begin
            step(1);
            chk_rd("per_count2", TMR_COUNT, 32'((i == 4) ? 3 : 3 - i));
        end

        // Write-1-to-clear, then clear colliding with an expire
        wr(TMR_STATUS, 32'h1);
        chk_rd("w1c_match", TMR_STATUS, 32'd0);
        chk_irq("w1c_irq", 1'b0);
        step(2);
        chk_rd("w1c_pre_exp", TMR_COUNT, 32'd0);
        wr(TMR_STATUS, 32'h1);
        chk_rd("w1c_set_wins", TMR_STATUS, 32'd1);
        chk_irq("w1c_set_wins_irq", 1'b1);
        chk_rd("w1c_reload", TMR_COUNT, 32'd3);
        wr(TMR_CTRL, 32'h0);
        wr(TMR_STATUS, 32'h1);
        chk_rd("w1c_final", TMR_STATUS, 32'd0);

        // One-shot with PS=3
        wr(TMR_LOAD, 32'd1);
        wr(TMR_COUNT, 32'd1);
        wr(TMR_CTRL, 32'h301);
        for (int i = 1; i <= 8; i++) begin
            step(1);
            chk_rd("os_match", TMR_STATUS, 32'(i == 8));
        end
        chk_rd("os_ctrl", TMR_CTRL, 32'h300);
        chk_rd("os_count", TMR_COUNT, 32'd0);
        chk_irq("os_irq", 1'b0);
        step(3);
        chk_rd("os_count_hold", TMR_COUNT, 32'd0);
        wr(TMR_STATUS, 32'h1);

        // COUNT write on a tick cycle, PS=1
        wr(TMR_LOAD, 32'd5);
        wr(TMR_COUNT, 32'd5);
        wr(TMR_CTRL, 32'h103);
        step(1);
        wr(TMR_COUNT, 32'h20);
        chk_rd("coll_count_wr", TMR_COUNT, 32'h20);
        step(1);
        chk_rd("coll_hold", TMR_COUNT, 32'h20);
        step(1);
        chk_rd("coll_dec", TMR_COUNT, 32'h1F);
        wr(TMR_CTRL, 32'h0);
        wr(TMR_STATUS, 32'h1);

        // LOAD write mid-run affects only the next reload
        wr(TMR_LOAD, 32'd2);
        wr(TMR_COUNT, 32'd2);
        wr(TMR_CTRL, 32'h3);
        wr(TMR_LOAD, 32'd9);
        chk_rd("ld_count1", TMR_COUNT, 32'd1);
        step(1);
        chk_rd("ld_count0", TMR_COUNT, 32'd0);
        step(1);
        chk_rd("ld_reload", TMR_COUNT, 32'd9);
        chk_rd("ld_match1", TMR_STATUS, 32'd1);
        wr(TMR_STATUS, 32'h1);
        chk_rd("ld_clr", TMR_STATUS, 32'd0);
        step(8);
        chk_rd("ld_p2_count", TMR_COUNT, 32'd0);
        chk_rd("ld_p2_nomatch", TMR_STATUS, 32'd0);
        step(1);
        chk_rd("ld_p2_reload", TMR_COUNT, 32'd9);
        chk_rd("ld_p2_match", TMR_STATUS, 32'd1);
        wr(TMR_CTRL, 32'h0);
        wr(TMR_STATUS, 32'h1);

        // Decode: unselected write ignored, empty offset, uptime delta
        wr(TMR_COUNT, 32'h55);
        HSEL = 1'b0; HWRITE = 1'b1; HADDR = TMR_COUNT; HWDATA = 32'hDEAD;
        @(negedge HCLK);
        HWRITE = 1'b0;
        chk_rd("dec_hsel0", TMR_COUNT, 32'h55);
        chk_rd("dec_off5", 3'd5, 32'd0);
        wr(TMR_UPTIME, 32'h0);
        chk_rd("dec_uptime_ro", TMR_UPTIME, up_cyc);
        rd(TMR_UPTIME, a0);
        n = $urandom_range(1, 50);
        step(n);
        rd(TMR_UPTIME, a1);
        chk("dec_uptime_delta", a1 - a0, 32'(n));

        // Randomized enable/run segments vs. arithmetic model
        for (int s = 0; s < 24; s++) begin
            int unsigned ps, ld, c0, ncyc, k, r;
            logic au, ie, en_e, m_e;
            logic [31:0] cnt_e;
            ps   = $urandom_range(0, 3);
            ld   = $urandom_range(0, 5);
            c0   = $urandom_range(0, 5);
            ncyc = $urandom_range(0, 60);
            au   = 1'($urandom_range(0, 1));
            ie   = 1'($urandom_range(0, 1));
            wr(TMR_CTRL, 32'h0);
            wr(TMR_STATUS, 32'h1);
            wr(TMR_LOAD, ld);
            wr(TMR_COUNT, c0);
            wr(TMR_CTRL, (ps << 8) | (32'(ie) << 2) | (32'(au) << 1) | 32'h1);
            step(int'(ncyc));

            // Ticks land every ps+1 cycles after the enable edge; the first
            // expiry is tick c0+1, later ones every ld+1 ticks.
            k = ncyc / (ps + 1);
            if (k <= c0) begin
                cnt_e = c0 - k; m_e = 1'b0; en_e = 1'b1;
            end else if (!au) begin
                cnt_e = 0; m_e = 1'b1; en_e = 1'b0;
            end else begin
                r = (k - c0 - 1) % (ld + 1);
                cnt_e = ld - r; m_e = 1'b1; en_e = 1'b1;
            end
            exp_q.push_back(cnt_e);
            exp_q.push_back({31'd0, m_e});
            exp_q.push_back((ps << 8) | (32'(ie) << 2) | (32'(au) << 1) | 32'(en_e));
            exp_q.push_back(up_cyc);
            exp_q.push_back({31'd0, m_e & ie});

            rd(TMR_COUNT, d);  chk($sformatf("rnd%0d_count", s), d, exp_q.pop_front());
            rd(TMR_STATUS, d); chk($sformatf("rnd%0d_status", s), d, exp_q.pop_front());
            rd(TMR_CTRL, d);   chk($sformatf("rnd%0d_ctrl", s), d, exp_q.pop_front());
            rd(TMR_UPTIME, d); chk($sformatf("rnd%0d_uptime", s), d, exp_q.pop_front());
            chk($sformatf("rnd%0d_irq", s), {31'd0, irq}, exp_q.pop_front());
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
